// File: rtl/ledger_txn_arbiter.sv
// Round-robin scheduler sharing the ledger core between NUM_PORTS requesters, with tag-based response routing.
// Optional LEDGER_ARB_STATS_EN adds 32-bit success/failure counters; otherwise stat_ok/stat_fail are tied to zero.
module ledger_txn_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int USER_WIDTH    = 10,
  parameter int BALANCE_WIDTH = 64,
  parameter int TAG_DEPTH     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PORTS-1:0]               req_valid,
  output logic [NUM_PORTS-1:0]               req_ready,
  input  logic [NUM_PORTS-1:0]               req_opcode,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]    req_user_a,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]    req_user_b,
  input  logic [NUM_PORTS*BALANCE_WIDTH-1:0] req_amount_0,
  input  logic [NUM_PORTS*BALANCE_WIDTH-1:0] req_amount_1,
  output logic                               core_valid,
  output logic                               core_opcode,
  output logic [USER_WIDTH-1:0]              core_user_a,
  output logic [USER_WIDTH-1:0]              core_user_b,
  output logic [BALANCE_WIDTH-1:0]           core_amount_0,
  output logic [BALANCE_WIDTH-1:0]           core_amount_1,
  input  logic                               core_rsp_valid,
  input  logic                               core_rsp_success,
  output logic [NUM_PORTS-1:0]               rsp_valid,
  output logic                               rsp_success,
  input  logic                               pause_req,
  output logic                               paused,
  output logic                               err_orphan,
  output logic [31:0]                        stat_ok,
  output logic [31:0]                        stat_fail
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]            grant_idx;
  logic                     grant_found;
  logic                     arb_en, xfer;

  logic [PW-1:0]            tag_mem [TAG_DEPTH];
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     fifo_empty, fifo_full, push, pop;

  logic                     core_valid_q, core_opcode_q;
  logic [USER_WIDTH-1:0]    core_user_a_q, core_user_b_q;
  logic [BALANCE_WIDTH-1:0] core_amount_0_q, core_amount_1_q;
  logic [NUM_PORTS-1:0]     rsp_valid_q;
  logic                     rsp_success_q;
  logic                     err_orphan_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after rr_ptr, scanning modulo NUM_PORTS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      int unsigned cand;
      cand = (32'(rr_ptr_q) + i) % NUM_PORTS;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
  end

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(TAG_DEPTH));
  // Full is judged on registered occupancy, so a same-cycle pop cannot enable a grant.
  assign arb_en     = rst_n && (state_q == RUN) && !pause_req && !fifo_full;
  assign xfer       = arb_en && grant_found;
  assign req_ready  = xfer ? (NUM_PORTS'(1) << grant_idx) : '0;
  assign push       = xfer;
  assign pop        = core_rsp_valid && !fifo_empty;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer)
      rr_ptr_d = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + 1'b1;
    else if (pop && !push)
      cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (pause_req) state_d = DRAIN;
      DRAIN: begin
        if (!pause_req)                       state_d = RUN;
        else if (fifo_empty && !core_valid_q) state_d = PAUSED;
      end
      PAUSED:  if (!pause_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr_q] <= grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      rr_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
      core_valid_q    <= 1'b0;
      core_opcode_q   <= 1'b0;
      core_user_a_q   <= '0;
      core_user_b_q   <= '0;
      core_amount_0_q <= '0;
      core_amount_1_q <= '0;
      rsp_valid_q     <= '0;
      rsp_success_q   <= 1'b0;
      err_orphan_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      core_valid_q <= xfer;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (xfer) begin
        core_opcode_q   <= req_opcode[grant_idx];
        core_user_a_q   <= req_user_a[grant_idx*USER_WIDTH +: USER_WIDTH];
        core_user_b_q   <= req_user_b[grant_idx*USER_WIDTH +: USER_WIDTH];
        core_amount_0_q <= req_amount_0[grant_idx*BALANCE_WIDTH +: BALANCE_WIDTH];
        core_amount_1_q <= req_amount_1[grant_idx*BALANCE_WIDTH +: BALANCE_WIDTH];
      end
      rsp_valid_q   <= pop ? (NUM_PORTS'(1) << tag_mem[rd_ptr_q]) : '0;
      rsp_success_q <= pop && core_rsp_success;
      if (core_rsp_valid && fifo_empty)
        err_orphan_q <= 1'b1;
    end
  end

`ifdef LEDGER_ARB_STATS_EN
  logic [31:0] stat_ok_q, stat_fail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok_q   <= '0;
      stat_fail_q <= '0;
    end else if (pop) begin
      if (core_rsp_success) stat_ok_q   <= stat_ok_q + 1'b1;
      else                  stat_fail_q <= stat_fail_q + 1'b1;
    end
  end

  assign stat_ok   = stat_ok_q;
  assign stat_fail = stat_fail_q;
`else
  assign stat_ok   = '0;
  assign stat_fail = '0;
`endif

  assign core_valid    = core_valid_q;
  assign core_opcode   = core_opcode_q;
  assign core_user_a   = core_user_a_q;
  assign core_user_b   = core_user_b_q;
  assign core_amount_0 = core_amount_0_q;
  assign core_amount_1 = core_amount_1_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_success   = rsp_success_q;
  assign paused        = (state_q == PAUSED);
  assign err_orphan    = err_orphan_q;

endmodule
